fetch_next_pc: RTL and testbench
================================

# fetch_next_pc

Next-PC generator and fetch controller directly upstream of the PC register. It takes the current PC back from the register's output, selects sequential, branch or jump targets, and drives the register's next-value input every cycle. It also sequences boot after reset, holds the PC during pipeline stalls, defers redirects that arrive during a stall, and emits the flush and valid strobes for the IF/ID latch.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- PC_STEP, 1, sequential increment (word-addressed imem)

- clk  in  1  rising-edge clock
- clear  in  1  reset; synchronous, active-high
- pc_cur  in  32  current PC, from PC register output
- pc_next  out  32  next PC, to PC register input
- stall  in  1  hold PC; from hazard unit
- br_taken  in  1  branch resolved taken (execute stage)
- br_target  in  32  absolute branch target
- jmp  in  1  jump decoded (decode stage)
- jmp_target  in  27  JI-format target, zero-extended to 32
- flush  out  1  squash IF/ID contents this cycle
- fetch_valid  out  1  pc_next is a real fetch address
- redirect_pending  out  1  a deferred redirect is held

## Operation
- States: BOOT, RUN, HOLD (plus HALT, see Configuration). Registered: state, pend_valid, pend_is_br, pend_target[31:0].
- clear=1: next state BOOT, pend_valid<=0. Same cycle outputs: pc_next=RESET_VECTOR, flush=0, fetch_valid=0, redirect_pending=0.
- BOOT: pc_next=RESET_VECTOR, fetch_valid=0, flush=0. Always -> RUN. Branch, jump and stall inputs are ignored.
- RUN, stall=0, no request: pc_next=pc_cur+PC_STEP, fetch_valid=1.
- RUN, stall=0, request: br_taken has priority over jmp.
  - pc_next=br_target or {5'b0,jmp_target}
  - flush=1, fetch_valid=1
- RUN, stall=1: pc_next=pc_cur, fetch_valid=0, flush=0.
  - Any request is latched into pend; state -> HOLD.
  - Otherwise state stays RUN.
- HOLD, stall=1: pc_next=pc_cur, fetch_valid=0.
  - A new request overwrites pend only if its priority is >= the pending one (branch > jump). A later branch replaces an earlier branch; a jump never replaces a branch.
- HOLD, stall=0:
  - If a live request exists with priority >= pend, the live request is used. Otherwise pend_target is used.
  - flush=1, fetch_valid=1, pend_valid<=0, state -> RUN.
- redirect_pending = pend_valid (registered).
- Arithmetic: 32-bit modulo. 32'hFFFF_FFFF + 1 -> 32'h0000_0000, with no flag.

## Timing
- pc_next, flush and fetch_valid are combinational from inputs plus registered state. The PC register captures pc_next on the same edge, so a redirect takes effect with 1-cycle latency.
- Exactly one flush pulse per applied redirect. No flush is issued while stalled.
- redirect_pending rises on the edge after a redirect is latched during a stall. It falls on the edge where that redirect is applied.
- clear asserted mid-HOLD discards the pending redirect. The first post-reset fetch address is always RESET_VECTOR.
- If stall and clear are asserted together, clear wins.

## Configuration
- FETCH_HALT_EN defined:
  - Adds input `halt` (1 bit) and state HALT.
  - halt=1 in RUN or HOLD enters HALT on the next edge; a pending redirect is discarded.
  - In HALT: pc_next=pc_cur, fetch_valid=0, flush=0. All inputs except clear are ignored.
  - Only clear exits HALT (-> BOOT).
- FETCH_HALT_EN undefined: no `halt` port and no HALT state. The three-state machine runs unchanged.

## Test plan
- Pulse clear with RESET_VECTOR=32'h100 -> pc_next=32'h100 with fetch_valid=0 for 2 cycles (clear, BOOT). Then 32'h101, 32'h102 with fetch_valid=1.
- In RUN at pc_cur=32'h20, assert br_taken with br_target=32'h80 and jmp with jmp_target=27'h40 together -> pc_next=32'h80 and flush=1 for one cycle.
- Hold stall=1 for 3 cycles with pc_cur=32'h10, pulse jmp (target 27'h50) in cycle 1 -> pc_next stays 32'h10 and redirect_pending=1 from cycle 2. After stall drops: pc_next=32'h50, flush=1, then redirect_pending=0.
- During stall, pend jmp 27'h50, then br_taken to 32'h90, then jmp 27'h60 -> on release pc_next=32'h90.
- Force pc_cur=32'hFFFF_FFFF with no request -> pc_next=32'h0000_0000, fetch_valid=1.
- With FETCH_HALT_EN: pulse halt -> fetch_valid=0 and pc_next=pc_cur indefinitely despite br_taken. Then clear -> BOOT -> RESET_VECTOR.

Source files
------------

// File: rtl/fetch_next_pc.sv
// Next-PC generator and fetch controller feeding the PC register: boot, stall hold,
// deferred redirects, IF/ID flush/valid. Optional halt state under `FETCH_HALT_EN.
module fetch_next_pc #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [26:0] jmp_target,
`ifdef FETCH_HALT_EN
  input  logic        halt,
`endif
  output logic        flush,
  output logic        fetch_valid,
  output logic        redirect_pending,
  output logic [1:0]  state_dbg
);

  // Handshake-free block: every output is valid every cycle; the PC register
  // downstream captures pc_next unconditionally on each rising edge.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
`ifdef FETCH_HALT_EN
    ,
    HALT = 2'd3
`endif
  } state_t;

  state_t      state, state_n;
  logic        pend_valid, pend_valid_n;
  logic        pend_is_br, pend_is_br_n;
  logic [31:0] pend_target, pend_target_n;

  logic        live_req;
  logic [31:0] live_target;
  logic        live_wins;

  assign live_req    = br_taken | jmp;
  assign live_target = br_taken ? br_target : {5'b0, jmp_target};
  // A live request beats the pending one unless it is a jump against a pending branch.
  assign live_wins   = br_taken | (jmp & ~pend_is_br);

  always_comb begin
    state_n       = state;
    pend_valid_n  = pend_valid;
    pend_is_br_n  = pend_is_br;
    pend_target_n = pend_target;
    pc_next       = pc_cur;
    flush         = 1'b0;
    fetch_valid   = 1'b0;

    case (state)
      BOOT: begin
        pc_next = RESET_VECTOR;
        state_n = RUN;
      end
      RUN: begin
        if (stall) begin
          if (live_req) begin
            pend_valid_n  = 1'b1;
            pend_is_br_n  = br_taken;
            pend_target_n = live_target;
            state_n       = HOLD;
          end
        end else begin
          fetch_valid = 1'b1;
          if (live_req) begin
            pc_next = live_target;
            flush   = 1'b1;
          end else begin
            pc_next = pc_cur + PC_STEP;
          end
        end
      end
      HOLD: begin
        if (stall) begin
          if (live_wins) begin
            pend_is_br_n  = br_taken;
            pend_target_n = live_target;
          end
        end else begin
          pc_next      = live_wins ? live_target : pend_target;
          flush        = 1'b1;
          fetch_valid  = 1'b1;
          pend_valid_n = 1'b0;
          state_n      = RUN;
        end
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        pc_next = pc_cur;
      end
`endif
      default: begin
        state_n = BOOT;
      end
    endcase

`ifdef FETCH_HALT_EN
    if (halt && (state == RUN || state == HOLD)) begin
      state_n      = HALT;
      pend_valid_n = 1'b0;
    end
`endif

    if (clear) begin
      state_n      = BOOT;
      pend_valid_n = 1'b0;
      pc_next      = RESET_VECTOR;
      flush        = 1'b0;
      fetch_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= BOOT;
      pend_valid  <= 1'b0;
      pend_is_br  <= 1'b0;
      pend_target <= 32'h0;
    end else begin
      state       <= state_n;
      pend_valid  <= pend_valid_n;
      pend_is_br  <= pend_is_br_n;
      pend_target <= pend_target_n;
    end
  end

  // Forced low during clear so the strobe is clean in the reset cycle itself.
  assign redirect_pending = pend_valid & ~clear;
  assign state_dbg        = state;

endmodule

// File: tb/tb_fetch_next_pc.sv
// Directed, table-driven bench for fetch_next_pc; each table row is one clock cycle.
`timescale 1ns/1ps
module tb_fetch_next_pc;

  logic        clk = 1'b0;
  logic        clear, stall, br_taken, jmp, halt;
  logic [31:0] pc_cur, br_target, pc_next;
  logic [26:0] jmp_target;
  logic        flush, fetch_valid, redirect_pending;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  int flush_cnt = 0;

  always #5 clk = ~clk;

  fetch_next_pc #(.RESET_VECTOR(32'h100), .PC_STEP(32'd1)) dut (
    .clk(clk),
    .clear(clear),
    .pc_cur(pc_cur),
    .pc_next(pc_next),
    .stall(stall),
    .br_taken(br_taken),
    .br_target(br_target),
    .jmp(jmp),
    .jmp_target(jmp_target),
`ifdef FETCH_HALT_EN
    .halt(halt),
`endif
    .flush(flush),
    .fetch_valid(fetch_valid),
    .redirect_pending(redirect_pending),
    .state_dbg(state_dbg)
  );

  typedef struct {
    string       name;
    logic        clear, stall, br, jmp, halt;
    logic [31:0] pc, bt;
    logic [26:0] jt;
    logic [31:0] e_pc;
    logic        e_f, e_fv, e_rp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic c, logic s, logic b, logic j,
                              logic [31:0] pc, logic [31:0] bt, logic [26:0] jt,
                              logic [31:0] e_pc, logic e_f, logic e_fv, logic e_rp);
    vec_t v;
    v.name = name; v.clear = c; v.stall = s; v.br = b; v.jmp = j; v.halt = 1'b0;
    v.pc = pc; v.bt = bt; v.jt = jt;
    v.e_pc = e_pc; v.e_f = e_f; v.e_fv = e_fv; v.e_rp = e_rp;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, check combinational outputs mid-cycle, then let the edge commit.
  task automatic apply(vec_t v);
    @(negedge clk);
    clear = v.clear; stall = v.stall; br_taken = v.br; jmp = v.jmp; halt = v.halt;
    pc_cur = v.pc; br_target = v.bt; jmp_target = v.jt;
    #2;
    check({v.name, ".pc_next"}, pc_next, v.e_pc);
    check({v.name, ".flush"}, {31'b0, flush}, {31'b0, v.e_f});
    check({v.name, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, v.e_fv});
    check({v.name, ".redirect_pending"}, {31'b0, redirect_pending}, {31'b0, v.e_rp});
    if (flush === 1'b1) flush_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f0;
    vec_t v;
    clear = 1'b1; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; halt = 1'b0;
    pc_cur = 32'h0; br_target = 32'h0; jmp_target = 27'h0;

    //                 name        c  s  b  j  pc_cur        br_tgt      jmp_tgt        exp_pc        f  fv rp
    vecs.push_back(mk("clear",     1, 0, 0, 0, 32'h55,       32'h0,      27'h0,         32'h100,      0, 0, 0));
    vecs.push_back(mk("boot",      0, 1, 1, 1, 32'h55,       32'h999,    27'h123,       32'h100,      0, 0, 0));
    vecs.push_back(mk("seq0",      0, 0, 0, 0, 32'h100,      32'h0,      27'h0,         32'h101,      0, 1, 0));
    vecs.push_back(mk("seq1",      0, 0, 0, 0, 32'h101,      32'h0,      27'h0,         32'h102,      0, 1, 0));
    vecs.push_back(mk("br_jmp",    0, 0, 1, 1, 32'h20,       32'h80,     27'h40,        32'h80,       1, 1, 0));
    vecs.push_back(mk("jmp_max",   0, 0, 0, 1, 32'h80,       32'h0,      27'h7FF_FFFF,  32'h07FF_FFFF,1, 1, 0));
    vecs.push_back(mk("post_jmp",  0, 0, 0, 0, 32'h81,       32'h0,      27'h0,         32'h82,       0, 1, 0));
    vecs.push_back(mk("st_jmp",    0, 1, 0, 1, 32'h10,       32'h0,      27'h50,        32'h10,       0, 0, 0));
    vecs.push_back(mk("st_hold1",  0, 1, 0, 0, 32'h10,       32'h0,      27'h0,         32'h10,       0, 0, 1));
    vecs.push_back(mk("st_hold2",  0, 1, 0, 0, 32'h10,       32'h0,      27'h0,         32'h10,       0, 0, 1));
    vecs.push_back(mk("st_rel",    0, 0, 0, 0, 32'h10,       32'h0,      27'h0,         32'h50,       1, 1, 1));
    vecs.push_back(mk("st_after",  0, 0, 0, 0, 32'h50,       32'h0,      27'h0,         32'h51,       0, 1, 0));
    vecs.push_back(mk("pr_jmp",    0, 1, 0, 1, 32'h30,       32'h0,      27'h50,        32'h30,       0, 0, 0));
    vecs.push_back(mk("pr_br",     0, 1, 1, 0, 32'h30,       32'h90,     27'h0,         32'h30,       0, 0, 1));
    vecs.push_back(mk("pr_jmp2",   0, 1, 0, 1, 32'h30,       32'h0,      27'h60,        32'h30,       0, 0, 1));
    vecs.push_back(mk("pr_rel",    0, 0, 0, 0, 32'h30,       32'h0,      27'h0,         32'h90,       1, 1, 1));
    vecs.push_back(mk("pr_after",  0, 0, 0, 0, 32'h90,       32'h0,      27'h0,         32'h91,       0, 1, 0));
    vecs.push_back(mk("bb_br1",    0, 1, 1, 0, 32'h40,       32'hA0,     27'h0,         32'h40,       0, 0, 0));
    vecs.push_back(mk("bb_br2",    0, 1, 1, 0, 32'h40,       32'hB0,     27'h0,         32'h40,       0, 0, 1));
    vecs.push_back(mk("bb_reljmp", 0, 0, 0, 1, 32'h40,       32'h0,      27'h70,        32'hB0,       1, 1, 1));
    vecs.push_back(mk("bb_after",  0, 0, 0, 0, 32'hB0,       32'h0,      27'h0,         32'hB1,       0, 1, 0));
    vecs.push_back(mk("lb_jmp",    0, 1, 0, 1, 32'h60,       32'h0,      27'h11,        32'h60,       0, 0, 0));
    vecs.push_back(mk("lb_relbr",  0, 0, 1, 0, 32'h60,       32'hC0,     27'h0,         32'hC0,       1, 1, 1));
    vecs.push_back(mk("lb_after",  0, 0, 0, 0, 32'hC0,       32'h0,      27'h0,         32'hC1,       0, 1, 0));
    vecs.push_back(mk("jj_jmp",    0, 1, 0, 1, 32'h70,       32'h0,      27'h22,        32'h70,       0, 0, 0));
    vecs.push_back(mk("jj_reljmp", 0, 0, 0, 1, 32'h70,       32'h0,      27'h33,        32'h33,       1, 1, 1));
    vecs.push_back(mk("jj_after",  0, 0, 0, 0, 32'h33,       32'h0,      27'h0,         32'h34,       0, 1, 0));
    vecs.push_back(mk("wrap",      0, 0, 0, 0, 32'hFFFF_FFFF,32'h0,      27'h0,         32'h0,        0, 1, 0));
    vecs.push_back(mk("st_noreq",  0, 1, 0, 0, 32'h5,        32'h0,      27'h0,         32'h5,        0, 0, 0));
    vecs.push_back(mk("st_norel",  0, 0, 0, 0, 32'h5,        32'h0,      27'h0,         32'h6,        0, 1, 0));
    vecs.push_back(mk("cl_jmp",    0, 1, 0, 1, 32'h8,        32'h0,      27'h44,        32'h8,        0, 0, 0));
    vecs.push_back(mk("cl_clear",  1, 1, 1, 0, 32'h8,        32'h77,     27'h0,         32'h100,      0, 0, 0));
    vecs.push_back(mk("cl_boot",   0, 1, 0, 0, 32'h8,        32'h0,      27'h0,         32'h100,      0, 0, 0));
    vecs.push_back(mk("cl_run",    0, 0, 0, 0, 32'h100,      32'h0,      27'h0,         32'h101,      0, 1, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // A branch re-asserted on every stalled cycle must still yield exactly one flush.
    f0 = flush_cnt;
    for (int i = 0; i < 4; i++)
      apply(mk("rep_br", 0, 1, 1, 0, 32'h3, 32'h400 + i, 27'h0, 32'h3, 0, 0, (i != 0)));
    apply(mk("rep_rel", 0, 0, 0, 0, 32'h3, 32'h0, 27'h0, 32'h403, 1, 1, 1));
    apply(mk("rep_run0", 0, 0, 0, 0, 32'h403, 32'h0, 27'h0, 32'h404, 0, 1, 0));
    apply(mk("rep_run1", 0, 0, 0, 0, 32'h404, 32'h0, 27'h0, 32'h405, 0, 1, 0));
    check("rep_flush_count", flush_cnt - f0, 32'd1);

`ifdef FETCH_HALT_EN
    v = mk("h_run", 0, 0, 0, 0, 32'h200, 32'h0, 27'h0, 32'h201, 0, 1, 0);
    v.halt = 1'b1;
    apply(v);
    for (int i = 0; i < 4; i++)
      apply(mk("h_halted", 0, i[0], 1, 1, 32'h300 + i, 32'h999, 27'h55, 32'h300 + i, 0, 0, 0));
    apply(mk("h_clear", 1, 0, 0, 0, 32'h303, 32'h0, 27'h0, 32'h100, 0, 0, 0));
    apply(mk("h_boot", 0, 0, 0, 0, 32'h303, 32'h0, 27'h0, 32'h100, 0, 0, 0));
    apply(mk("h_run2", 0, 0, 0, 0, 32'h100, 32'h0, 27'h0, 32'h101, 0, 1, 0));
    apply(mk("hp_jmp", 0, 1, 0, 1, 32'h8, 32'h0, 27'h66, 32'h8, 0, 0, 0));
    v = mk("hp_halt", 0, 1, 0, 0, 32'h8, 32'h0, 27'h0, 32'h8, 0, 0, 1);
    v.halt = 1'b1;
    apply(v);
    apply(mk("hp_halted", 0, 0, 0, 0, 32'h8, 32'h0, 27'h0, 32'h8, 0, 0, 0));
    apply(mk("hp_clear", 1, 0, 0, 0, 32'h8, 32'h0, 27'h0, 32'h100, 0, 0, 0));
    apply(mk("hp_boot", 0, 0, 0, 0, 32'h8, 32'h0, 27'h0, 32'h100, 0, 0, 0));
`else
    v = mk("tail", 0, 0, 0, 0, 32'h405, 32'h0, 27'h0, 32'h406, 0, 1, 0);
    apply(v);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
